// File: rtl/nn_pkg.sv
// Shared fixed-point neuron definitions: MAC FSM states and saturation bounds
// used by both the MAC and the ReLU activation stage.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/serial_mac_neuron_if.sv
// Beat-in / result-out handshake bundle between a feeder and the serial MAC neuron.
interface serial_mac_neuron_if #(
  parameter int M = 8
);
  logic                in_valid;
  logic                in_ready;
  logic signed [M-1:0] x;
  logic signed [M-1:0] w;
  logic signed [M-1:0] bias;
  logic                out_valid;
  logic                out_ready;
  logic signed [M-1:0] y;

  modport master (
    output in_valid, x, w, bias, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, w, bias, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fx_sat_trunc.sv
// Drops FRAC fraction bits (floor, via arithmetic shift) and clamps the
// result into a signed OUT_W range.
module fx_sat_trunc
  import nn_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8,
  parameter int FRAC  = 5
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(sat_hi(OUT_W));
  localparam logic signed [IN_W-1:0] LO = IN_W'(sat_lo(OUT_W));

  function automatic logic signed [OUT_W-1:0] sat_trunc(input logic signed [IN_W-1:0] v);
    logic signed [IN_W-1:0] s;
    s = v >>> FRAC;
    if (s > HI)      return OUT_W'(HI);
    else if (s < LO) return OUT_W'(LO);
    else             return OUT_W'(s);
  endfunction

  assign dout = sat_trunc(din);

endmodule

// File: rtl/serial_mac_neuron.sv
// Serial multiply-accumulate neuron: K x*w beats plus a bias, one result
// per evaluation, saturated to Q(M-FRAC).FRAC for the ReLU stage.
module serial_mac_neuron
  import nn_pkg::*;
#(
  parameter int M    = 8,
  parameter int FRAC = 5,
  parameter int K    = 4
) (
  input logic                clk,
  input logic                rst,
  serial_mac_neuron_if.slave bus
);

  localparam int AW = 2*M + $clog2(K) + 1;
  localparam int CW = $clog2(K + 1);

  state_t                 state, state_nxt;
  logic signed [AW-1:0]   acc_p0, acc_nxt;
  logic        [CW-1:0]   cnt_p0, cnt_nxt;
  logic signed [M-1:0]    y_p1, y_sat;
  logic signed [2*M-1:0]  prod;
  logic                   load_y;
  logic                   in_ready_c, out_valid_c;

  assign prod = bus.x * bus.w;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc_p0;
    cnt_nxt     = cnt_p0;
    load_y      = 1'b0;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !rst;
        if (bus.in_valid) begin
          // Bias is aligned to the product's 2*FRAC fraction bits.
          acc_nxt = (AW'(bus.bias) <<< FRAC) + AW'(prod);
          cnt_nxt = CW'(1);
          if (K == 1) begin
            state_nxt = OUT;
            load_y    = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        in_ready_c = !rst;
        if (bus.in_valid) begin
          acc_nxt = acc_p0 + AW'(prod);
          cnt_nxt = cnt_p0 + CW'(1);
          if (cnt_p0 == CW'(K - 1)) begin
            state_nxt = OUT;
            load_y    = 1'b1;
          end
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result is taken from the accumulator value being written on the final beat.
  fx_sat_trunc #(
    .IN_W (AW),
    .OUT_W(M),
    .FRAC (FRAC)
  ) u_sat (
    .din (acc_nxt),
    .dout(y_sat)
  );

  // Stage boundary: accumulator state (p0) and registered output (p1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc_p0 <= '0;
      cnt_p0 <= '0;
      y_p1   <= '0;
    end else begin
      state  <= state_nxt;
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_nxt;
      if (load_y) y_p1 <= y_sat;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.y         = y_p1;

endmodule

// File: tb/tb_serial_mac_neuron.sv
// Directed bench for serial_mac_neuron (M=8, FRAC=5, K=4): vector table plus
// hand-written bubble, backpressure and reset sequences.
module tb_serial_mac_neuron;

  localparam int M    = 8;
  localparam int FRAC = 5;
  localparam int K    = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  serial_mac_neuron_if #(.M(M)) bus ();

  serial_mac_neuron #(.M(M), .FRAC(FRAC), .K(K)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    bias;
    int    xs[K];
    int    ws[K];
    int    y;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(string n, int b, int x0, int x1, int x2, int x3,
                              int w0, int w1, int w2, int w3, int y);
    vec_t v;
    v.name = n;
    v.bias = b;
    v.xs   = '{x0, x1, x2, x3};
    v.ws   = '{w0, w1, w2, w3};
    v.y    = y;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.w        = '0;
    bus.bias     = '0;
  endtask

  // Drives K beats with `gap` bubble cycles between them; later beats carry a
  // junk bias that must be ignored. Ends one cycle after the K-th beat.
  task automatic run_eval(input vec_t v, input int gap);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      chk({v.name, "_in_ready"}, int'(bus.in_ready), 1);
      chk({v.name, "_early_valid"}, int'(bus.out_valid), 0);
      bus.in_valid = 1'b1;
      bus.x        = M'(v.xs[i]);
      bus.w        = M'(v.ws[i]);
      bus.bias     = (i == 0) ? M'(v.bias) : M'(99);
      if (gap > 0 && i < K - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.x        = M'(77);
          bus.w        = M'(77);
          chk({v.name, "_bubble_valid"}, int'(bus.out_valid), 0);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    chk({v.name, "_out_valid"}, int'(bus.out_valid), 1);
    chk({v.name, "_y"}, int'(bus.y), v.y);
    chk({v.name, "_ready_in_out"}, int'(bus.in_ready), 0);
  endtask

  task automatic consume(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, "_consumed_valid"}, int'(bus.out_valid), 0);
    chk({name, "_consumed_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    vecs[0] = mk("half",      0,  32,  32,  32,  32,  16, 16, 16, 16,   64);
    vecs[1] = mk("pos_sat",   0,  32,  32,  32,  32,  32, 32, 32, 32,  127);
    vecs[2] = mk("neg_sat",   0, -96, -96, -96, -96,  96, 96, 96, 96, -128);
    vecs[3] = mk("trunc_pos", 0,   1,   1,   1,   1,   1,  1,  1,  1,    0);
    vecs[4] = mk("trunc_neg", 0,  -1,  -1,  -1,  -1,   1,  1,  1,  1,   -1);
    vecs[5] = mk("bias_only", 16,  0,   0,   0,   0,   0,  0,  0,  0,   16);
    vecs[6] = mk("mixed",     32, 10, -20,  30, -40,   5,  5,  5,  5,   28);
    vecs[7] = mk("bias_min", -128, 0,   0,   0,   0,   0,  0,  0,  0, -128);

    rst           = 1'b1;
    bus.out_ready = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_y", int'(bus.y), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", int'(bus.in_ready), 1);
    chk("post_reset_out_valid", int'(bus.out_valid), 0);

    for (int i = 0; i < 8; i++) begin
      run_eval(vecs[i], 0);
      consume(vecs[i].name);
    end

    // Bubbles between beats, then 3 cycles of backpressure with junk offered.
    run_eval(vecs[0], 2);
    bus.in_valid = 1'b1;
    bus.x        = M'(127);
    bus.w        = M'(127);
    bus.bias     = M'(127);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_y_stable", int'(bus.y), 64);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    idle_inputs();
    consume("bp");
    run_eval(vecs[5], 0);
    consume("after_bp");

    // Reset after two beats: partial sum must be discarded.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x        = M'(127);
      bus.w        = M'(127);
      bus.bias     = M'(127);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", int'(bus.in_ready), 0);
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rel_in_ready", int'(bus.in_ready), 1);
    chk("midrst_rel_out_valid", int'(bus.out_valid), 0);
    run_eval(vecs[0], 0);
    consume("after_midrst");

    // Reset while a result waits in OUT: no stale y afterwards.
    run_eval(vecs[1], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("outrst_out_valid", int'(bus.out_valid), 0);
    chk("outrst_y", int'(bus.y), 0);
    chk("outrst_in_ready", int'(bus.in_ready), 1);
    run_eval(vecs[3], 1);
    consume("after_outrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
